// File: rtl/kernel_fdtd_2d_mul_arb_if.sv
// Requester/response bundle for the shared index-multiplier arbiter.
interface kernel_fdtd_2d_mul_arb_if #(
  parameter int NREQ = 3,
  parameter int A_W  = 10,
  parameter int B_W  = 11,
  parameter int P_W  = 20
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*A_W-1:0] req_a;
  logic [NREQ*B_W-1:0] req_b;
  logic [NREQ-1:0]     rsp_valid;
  logic [P_W-1:0]      rsp_p;
  logic                busy;

  modport master (output req_valid, req_a, req_b,
                  input  req_ready, rsp_valid, rsp_p, busy);
  modport slave  (input  req_valid, req_a, req_b,
                  output req_ready, rsp_valid, rsp_p, busy);
endinterface

// File: rtl/kernel_fdtd_2d_mul_arb.sv
// Round-robin share of one unsigned A_W x B_W multiplier among NREQ requesters;
// each product returns on a one-hot strobe to the requester that issued it.
module kernel_fdtd_2d_mul_arb #(
  parameter int NREQ    = 3,
  parameter int A_W     = 10,
  parameter int B_W     = 11,
  parameter int P_W     = 20,
  parameter int MUL_LAT = 2
) (
  input  logic ap_clk,
  input  logic ap_rst,
  input  logic ap_ce,
  kernel_fdtd_2d_mul_arb_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]                  ptr_q, ptr_d;
  logic [NREQ-1:0]                gnt;
  logic [PW-1:0]                  gnt_idx;
  logic                           found;
  logic [PW:0]                    idx_v;
  logic [A_W-1:0]                 a_sel, a_q, a_d;
  logic [B_W-1:0]                 b_sel, b_q, b_d;
  logic [MUL_LAT:1]               vld_pipe_q, vld_pipe_d;
  logic [MUL_LAT:1][NREQ-1:0]     tag_q, tag_d;
  logic [P_W-1:0]                 mul_p;

  // Scan ptr, ptr+1, ... and take the first valid requester.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx_v   = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx_v = {1'b0, ptr_q} + (PW+1)'(off);
      if (idx_v >= (PW+1)'(NREQ)) idx_v = idx_v - (PW+1)'(NREQ);
      if (ap_ce && !found && bus.req_valid[idx_v[PW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = idx_v[PW-1:0];
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        a_sel = bus.req_a[i*A_W +: A_W];
        b_sel = bus.req_b[i*B_W +: B_W];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    a_d           = found ? a_sel : a_q;
    b_d           = found ? b_sel : b_q;
    vld_pipe_d    = '0;
    tag_d         = '0;
    vld_pipe_d[1] = found;
    tag_d[1]      = gnt;
    for (int j = 2; j <= MUL_LAT; j++) begin
      vld_pipe_d[j] = vld_pipe_q[j-1];
      tag_d[j]      = tag_q[j-1];
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ptr_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      vld_pipe_q <= '0;
      tag_q      <= '0;
    end else if (ap_ce) begin
      ptr_q      <= ptr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      vld_pipe_q <= vld_pipe_d;
      tag_q      <= tag_d;
    end
  end

  // Low P_W bits of the product depend only on the low P_W bits of each operand.
  assign mul_p = P_W'(a_q) * P_W'(b_q);

  generate
    if (MUL_LAT == 1) begin : g_lat1
      assign bus.rsp_p = mul_p;
    end else begin : g_latn
      logic [MUL_LAT-1:1][P_W-1:0] prod_q, prod_d;

      always_comb begin
        prod_d = prod_q;
        if (vld_pipe_q[1]) prod_d[1] = mul_p;
        for (int j = 2; j < MUL_LAT; j++)
          if (vld_pipe_q[j]) prod_d[j] = prod_q[j-1];
      end

      always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst)     prod_q <= '0;
        else if (ap_ce) prod_q <= prod_d;
      end

      assign bus.rsp_p = prod_q[MUL_LAT-1];
    end
  endgenerate

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = tag_q[MUL_LAT] & {NREQ{ap_ce}};
  assign bus.busy      = |vld_pipe_q;
endmodule

// File: tb/tb_kernel_fdtd_2d_mul_arb.sv
// Directed scoreboard bench for the shared multiplier arbiter.
module tb_kernel_fdtd_2d_mul_arb;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic ap_ce  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic [2:0]  tag;
    logic [19:0] p;
  } exp_t;
  exp_t sb[$];

  kernel_fdtd_2d_mul_arb_if #(.NREQ(3), .A_W(10), .B_W(11), .P_W(20)) bus ();

  kernel_fdtd_2d_mul_arb #(.NREQ(3), .A_W(10), .B_W(11), .P_W(20), .MUL_LAT(2)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .ap_ce  (ap_ce),
    .bus    (bus)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response strobe must match the oldest outstanding expectation.
  always @(negedge ap_clk) begin
    if (bus.rsp_valid !== 3'b000) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp act=%0d exp=none @%0t", bus.rsp_valid, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_tag", 32'(bus.rsp_valid), 32'(e.tag));
        chk("rsp_p",   32'(bus.rsp_p),     32'(e.p));
      end
    end
  end

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic op(input int idx, input logic [9:0] a, input logic [10:0] b);
    bus.req_a[idx*10 +: 10] = a;
    bus.req_b[idx*11 +: 11] = b;
  endtask

  task automatic issue(input logic [2:0] v, input logic [2:0] exp_g, input logic [19:0] exp_p);
    exp_t e;
    bus.req_valid = v;
    @(negedge ap_clk);
    chk("grant", 32'(bus.req_ready), 32'(exp_g));
    if (exp_g != 3'b000) begin
      e.tag = exp_g;
      e.p   = exp_p;
      sb.push_back(e);
    end
    step();
  endtask

  task automatic idle(input int n);
    bus.req_valid = 3'b000;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bus.req_valid = 3'b000;
    bus.req_a     = '0;
    bus.req_b     = '0;
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_p",     32'(bus.rsp_p),     0);
    chk("rst_busy",      32'(bus.busy),      0);
    chk("rst_ready",     32'(bus.req_ready), 0);
    step(); step();
    ap_rst = 1'b0;
    step();

    // single request, latency and busy window
    op(0, 5, 7);
    issue(3'b001, 3'b001, 20'd35);
    bus.req_valid = 3'b000;
    chk("busy_c0", 32'(bus.busy), 1);
    chk("rsp_early", 32'(bus.rsp_valid), 0);
    step();
    chk("busy_c1", 32'(bus.busy), 1);
    chk("rsp_on_time", 32'(bus.rsp_valid), 32'(3'b001));
    step();
    chk("busy_c2", 32'(bus.busy), 0);
    chk("rsp_one_cycle", 32'(bus.rsp_valid), 0);

    // truncation (ptr=1, only requester 0 valid)
    op(0, 1023, 2047);
    issue(3'b001, 3'b001, 20'd1045505);
    op(0, 0, 2047);
    issue(3'b001, 3'b001, 20'd0);

    // move ptr to 0 via requester 2, then fairness
    op(2, 1, 1);
    issue(3'b100, 3'b100, 20'd1);
    op(0, 2, 3);
    op(1, 10, 100);
    op(2, 1023, 1024);
    for (int r = 0; r < 2; r++) begin
      issue(3'b111, 3'b001, 20'd6);
      issue(3'b111, 3'b010, 20'd1000);
      issue(3'b111, 3'b100, 20'd1047552);
    end

    // pointer behaviour
    op(1, 4, 5);
    issue(3'b010, 3'b010, 20'd20);
    op(0, 7, 8);
    issue(3'b001, 3'b001, 20'd56);
    issue(3'b111, 3'b010, 20'd20);
    idle(4);

    // stall mid-flight with everyone requesting
    op(0, 3, 4);
    issue(3'b001, 3'b001, 20'd12);
    ap_ce = 1'b0;
    bus.req_valid = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      chk("stall_ready", 32'(bus.req_ready), 0);
      chk("stall_rsp",   32'(bus.rsp_valid), 0);
      chk("stall_busy",  32'(bus.busy),      1);
      step();
    end
    ap_ce = 1'b1;
    idle(4);

    // async reset with two requests in flight
    op(0, 6, 7);
    issue(3'b001, 3'b001, 20'd42);
    op(1, 9, 9);
    issue(3'b010, 3'b010, 20'd81);
    bus.req_valid = 3'b000;
    ap_rst = 1'b1;
    sb.delete();
    #1;
    chk("arst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("arst_busy",      32'(bus.busy),      0);
    step();
    ap_rst = 1'b0;
    idle(3);
    issue(3'b111, 3'b001, 20'd42);
    idle(4);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/kernel_fdtd_2d_mul_arb.md
Name: kernel_fdtd_2d_mul_arb

Overview:
Round-robin arbiter and pipeline wrapper that shares a single unsigned 10x11 multiplier among NREQ requesters. Typical requesters are the ex/ey/hz index generators computing row*NY+col offsets. One operand pair is accepted per cycle. Each product is tagged and returned only to the requester that issued it, so address generation needs one DSP instead of one per array.

Parameters:
NREQ, 3, number of requesters (2..8)
A_W, 10, width of operand a (unsigned)
B_W, 11, width of operand b (unsigned)
P_W, 20, product width; product is truncated to its low P_W bits
MUL_LAT, 2, register stages from acceptance to response (1..4)

Ports:
ap_clk  in  1  clock, rising edge
ap_rst  in  1  asynchronous active-high reset
ap_ce  in  1  clock enable; 0 stalls the whole block
req_valid  in  NREQ  per-requester operand valid
req_ready  out  NREQ  per-requester grant, one-hot or zero
req_a  in  NREQ*A_W  operand a, requester i at bits [i*A_W +: A_W]
req_b  in  NREQ*B_W  operand b, requester i at bits [i*B_W +: B_W]
rsp_valid  out  NREQ  one-hot result strobe, one cycle per accepted request
rsp_p  out  P_W  shared product bus, meaningful only while rsp_valid != 0
busy  out  1  1 while any pipeline stage holds a valid entry

Behaviour:
- Reset: ap_rst is async; all stage valid bits 0, rsp_valid 0, rsp_p 0, busy 0, priority pointer ptr 0. Asserting reset mid-operation drops in-flight requests; no response is ever produced for them.
- Arbitration (combinational):
  - When ap_ce=1, req_ready[g]=1 for exactly one g: the first i with req_valid[i]=1, scanning ptr, ptr+1, ... mod NREQ.
  - req_ready=0 when no request is valid or when ap_ce=0.
  - req_ready depends on req_valid; requesters must not make req_valid depend on req_ready.
- Handshake: a transfer occurs at a rising edge where req_valid[g] & req_ready[g] = 1. Requesters hold req_valid and their operands stable until a transfer occurs.
- Pointer: after a transfer to g, ptr <= (g+1) mod NREQ. ptr holds when there is no transfer or ap_ce=0.
- Pipeline:
  - Stage 1 registers a, b and the one-hot tag of g.
  - The remaining stages carry the product and tag.
  - Product = (a*b) mod 2^P_W, unsigned, full-precision multiply then truncate.
- Latency: a request accepted at edge k drives rsp_valid[g]=1 and rsp_p with its product during the cycle after edge k+MUL_LAT-1, for exactly one cycle. rsp_p holds its last value otherwise.
- Throughput: 1 request per cycle. With all requesters continuously valid, each is granted exactly once every NREQ cycles, so there is no starvation.
- Responses cannot be backpressured; requesters must accept rsp_valid whenever it occurs.
- Stall (ap_ce=0):
  - All pipeline registers and ptr hold; rsp_valid is forced to 0.
  - A response that was being presented reappears for one cycle when ap_ce returns to 1.
  - Nothing is lost or duplicated.
- Simultaneous events:
  - A new acceptance and a response retiring in the same edge are independent.
  - busy = OR of all stage valid bits (registered state), ignoring the current request.
- Operands are zero-extended; no signed interpretation.

Test Plan:
- Reset then single request: req_valid=001, a=5, b=7 accepted at edge 0 -> rsp_valid=001, rsp_p=35 after edge 1 for one cycle; busy high for 2 cycles.
- Truncation: a=1023, b=2047 -> rsp_p=1045505 (2094081 mod 2^20); a=0, b=2047 -> 0.
- Round-robin fairness: req_valid=111 held for 6 cycles with distinct operands -> grant order 0,1,2,0,1,2; each rsp_valid bit carries its own correct product in the same order.
- Pointer behaviour: grant to 1, then only requester 0 valid -> granted immediately; then 111 -> grant to 1.
- Stall mid-flight: accept a=3, b=4 (product 12), drop ap_ce for 3 cycles -> req_ready=000 and rsp_valid=000 throughout; after ap_ce=1, one response of 12 with no duplication.
- Async reset mid-flight: assert ap_rst between edges with 2 requests in flight -> rsp_valid and busy drop to 0 immediately; no responses after release; next grant starts from requester 0.
